// File: rtl/midi_voice_allocator.sv
// MIDI byte-stream parser with a small polyphonic voice allocator.
// Tracks running status, assigns notes to voice slots, and keeps CC1 / pitch-bend state.
module midi_voice_allocator #(
    parameter int           NUM_VOICES   = 4,
    parameter int           OMNI         = 1,
    parameter logic [3:0]   MIDI_CHANNEL = 4'd0
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    output logic [NUM_VOICES-1:0]     voice_active,
    output logic [7*NUM_VOICES-1:0]   voice_note,
    output logic [7*NUM_VOICES-1:0]   voice_velocity,
    output logic [NUM_VOICES-1:0]     voice_trigger,
    output logic [6:0]                mod_value,
    output logic [13:0]               pitch_bend
);

    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_BEND     = 4'hE;

    localparam logic [6:0] CC_MOD       = 7'd1;
    localparam logic [6:0] CC_ALL_OFF   = 7'd123;

    logic [3:0]                   r_status;
    logic [3:0]                   r_chan;
    logic                         r_rs_valid;
    logic                         r_cnt;
    logic [6:0]                   r_d0;
    logic [NUM_VOICES-1:0]        r_active;
    logic [NUM_VOICES-1:0][6:0]   r_note;
    logic [NUM_VOICES-1:0][6:0]   r_vel;
    logic [NUM_VOICES-1:0]        r_trig;
    logic [6:0]                   r_mod;
    logic [13:0]                  r_bend;
    logic [PW-1:0]                r_steal;

    logic          w_is_status;
    logic          w_is_data;
    logic          w_len_one;
    logic          w_done;
    logic          w_chan_ok;
    logic          w_exec;
    logic [6:0]    w_d0;
    logic [6:0]    w_d1;
    logic          w_note_on;
    logic          w_note_off;
    logic          w_cc;
    logic          w_bend;
    logic          w_hit;
    logic [PW-1:0] w_hit_idx;
    logic          w_free;
    logic [PW-1:0] w_free_idx;

    assign w_is_status = byte_valid && byte_data[7];
    assign w_is_data   = byte_valid && !byte_data[7] && r_rs_valid;
    assign w_len_one   = (r_status == ST_PROG) || (r_status == ST_CHAN_AT);
    assign w_done      = w_is_data && (w_len_one || r_cnt);
    assign w_chan_ok   = (OMNI != 0) || (r_chan == MIDI_CHANNEL);
    assign w_exec      = w_done && w_chan_ok;

    // A one-byte message carries its only data byte in the current byte.
    assign w_d0 = w_len_one ? byte_data[6:0] : r_d0;
    assign w_d1 = byte_data[6:0];

    assign w_note_on  = w_exec && (r_status == ST_NOTE_ON) && (w_d1 != 7'd0);
    assign w_note_off = w_exec && ((r_status == ST_NOTE_OFF) ||
                                   ((r_status == ST_NOTE_ON) && (w_d1 == 7'd0)));
    assign w_cc       = w_exec && (r_status == ST_CC);
    assign w_bend     = w_exec && (r_status == ST_BEND);

    // Scan high-to-low so the lowest matching / free index is the one kept.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && (r_note[v] == w_d0)) begin
                w_hit     = 1'b1;
                w_hit_idx = PW'(v);
            end
            if (!r_active[v]) begin
                w_free     = 1'b1;
                w_free_idx = PW'(v);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_status   <= 4'h0;
            r_chan     <= 4'h0;
            r_rs_valid <= 1'b0;
            r_cnt      <= 1'b0;
            r_d0       <= 7'd0;
            r_active   <= '0;
            // NOTE: the voice slots drive outputs that must read zero in reset, so they are reset too.
            r_note     <= '0;
            r_vel      <= '0;
            r_trig     <= '0;
            r_mod      <= 7'd0;
            r_bend     <= 14'h2000;
            r_steal    <= '0;
        end else begin
            // NOTE: non-blocking throughout; later assignments below override this default pulse clear.
            r_trig <= '0;

            if (w_is_status) begin
                if (byte_data[7:4] != 4'hF) begin
                    r_status   <= byte_data[7:4];
                    r_chan     <= byte_data[3:0];
                    r_rs_valid <= 1'b1;
                    r_cnt      <= 1'b0;
                end else if (!byte_data[3]) begin
                    r_rs_valid <= 1'b0;
                end
            end else if (w_is_data) begin
                if (w_done) begin
                    r_cnt <= 1'b0;
                end else begin
                    r_cnt <= 1'b1;
                    r_d0  <= byte_data[6:0];
                end
            end

            if (w_note_on) begin
                if (w_hit) begin
                    r_vel[w_hit_idx]  <= w_d1;
                    r_trig[w_hit_idx] <= 1'b1;
                end else if (w_free) begin
                    r_note[w_free_idx]   <= w_d0;
                    r_vel[w_free_idx]    <= w_d1;
                    r_active[w_free_idx] <= 1'b1;
                    r_trig[w_free_idx]   <= 1'b1;
                end else begin
                    r_note[r_steal] <= w_d0;
                    r_vel[r_steal]  <= w_d1;
                    r_trig[r_steal] <= 1'b1;
                    r_steal <= (r_steal == PW'(NUM_VOICES - 1)) ? '0 : r_steal + 1'b1;
                end
            end

            if (w_note_off && w_hit) begin
                r_active[w_hit_idx] <= 1'b0;
            end

            if (w_cc) begin
                if (w_d0 == CC_MOD) begin
                    r_mod <= w_d1;
                end else if (w_d0 == CC_ALL_OFF) begin
                    r_active <= '0;
                end
            end

            if (w_bend) begin
                r_bend <= {w_d1, w_d0};
            end
        end
    end

    assign voice_active   = r_active;
    assign voice_note     = r_note;
    assign voice_velocity = r_vel;
    assign voice_trigger  = r_trig;
    assign mod_value      = r_mod;
    assign pitch_bend     = r_bend;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator: an OMNI instance and a channel-2-only instance.
module tb_midi_voice_allocator;

    logic        clk;
    logic        rst_n;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic [3:0]  a_active, a_trig, b_active, b_trig;
    logic [27:0] a_note, a_vel, b_note, b_vel;
    logic [6:0]  a_mod, b_mod;
    logic [13:0] a_bend, b_bend;

    int total = 0;
    int bad   = 0;

    midi_voice_allocator #(.NUM_VOICES(4), .OMNI(1), .MIDI_CHANNEL(4'd0)) dut_omni (
        .CLOCK_50(clk), .RESET_N(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .voice_active(a_active), .voice_note(a_note), .voice_velocity(a_vel),
        .voice_trigger(a_trig), .mod_value(a_mod), .pitch_bend(a_bend)
    );

    midi_voice_allocator #(.NUM_VOICES(4), .OMNI(0), .MIDI_CHANNEL(4'd2)) dut_ch2 (
        .CLOCK_50(clk), .RESET_N(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .voice_active(b_active), .voice_note(b_note), .voice_velocity(b_vel),
        .voice_trigger(b_trig), .mod_value(b_mod), .pitch_bend(b_bend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one byte for one cycle; returns on the negedge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_active", a_active, 4'h0);
        check("rst_note",   a_note,   28'h0);
        check("rst_vel",    a_vel,    28'h0);
        check("rst_trig",   a_trig,   4'h0);
        check("rst_mod",    a_mod,    7'h00);
        check("rst_bend",   a_bend,   14'h2000);
        rst_n = 1'b1;

        // Basic Note On and running-status release
        send(8'h90); send(8'h3C);
        check("half_msg_active", a_active, 4'h0);
        check("half_msg_trig",   a_trig,   4'h0);
        send(8'h64);
        check("on_active", a_active, 4'b0001);
        check("on_note0",  a_note[6:0], 7'h3C);
        check("on_vel0",   a_vel[6:0],  7'h64);
        check("on_trig",   a_trig, 4'b0001);
        @(negedge clk);
        check("trig_one_cycle", a_trig, 4'h0);
        send(8'h40); send(8'h50);
        check("rs_active", a_active, 4'b0011);
        check("rs_note1",  a_note[13:7], 7'h40);
        check("rs_trig",   a_trig, 4'b0010);
        send(8'h3C); send(8'h00);
        check("vel0_off_active", a_active, 4'b0010);
        check("vel0_off_note0",  a_note[6:0], 7'h3C);
        check("vel0_off_trig",   a_trig, 4'h0);

        // Fill all voices, then steal round-robin
        do_reset();
        send(8'h90);
        for (int n = 0; n < 4; n++) begin
            send(8'h30 + 8'(n)); send(8'h7F);
        end
        check("full_active", a_active, 4'hF);
        check("full_notes",  a_note, {7'h33, 7'h32, 7'h31, 7'h30});
        send(8'h34); send(8'h7F);
        check("steal0_notes", a_note, {7'h33, 7'h32, 7'h31, 7'h34});
        check("steal0_trig",  a_trig, 4'b0001);
        send(8'h35); send(8'h7F);
        check("steal1_notes",  a_note, {7'h33, 7'h32, 7'h35, 7'h34});
        check("steal1_trig",   a_trig, 4'b0010);
        check("steal1_active", a_active, 4'hF);
        send(8'h35); send(8'h20);
        check("retrig_vel",   a_vel, {7'h7F, 7'h7F, 7'h20, 7'h7F});
        check("retrig_trig",  a_trig, 4'b0010);
        check("retrig_notes", a_note, {7'h33, 7'h32, 7'h35, 7'h34});
        send(8'h80); send(8'h50); send(8'h00);
        check("off_nomatch", a_active, 4'hF);
        send(8'h32); send(8'h00);
        check("off_match", a_active, 4'b1011);
        send(8'h90); send(8'h60); send(8'h10);
        check("refill_active", a_active, 4'hF);
        check("refill_notes",  a_note, {7'h33, 7'h60, 7'h35, 7'h34});
        check("refill_trig",   a_trig, 4'b0100);

        // Real-time bytes are transparent, system common kills running status
        do_reset();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        check("rt_active", a_active, 4'b0001);
        check("rt_note0",  a_note[6:0], 7'h3C);
        check("rt_trig",   a_trig, 4'b0001);
        do_reset();
        send(8'h90); send(8'h3C); send(8'hF2); send(8'h64);
        check("syscom_active", a_active, 4'h0);
        send(8'h3C); send(8'h64);
        check("syscom_rs_gone", a_active, 4'h0);
        send(8'hB5); send(8'h01); send(8'h33);
        check("omni_mod", a_mod, 7'h33);
        send(8'hE0); send(8'h7F); send(8'h01);
        check("bend_order", a_bend, {7'h01, 7'h7F});

        // Channel filter on the channel-2 instance
        do_reset();
        send(8'h91); send(8'h3C); send(8'h64);
        check("ch_filter_b", b_active, 4'h0);
        check("ch_filter_a", a_active, 4'b0001);
        send(8'hB2); send(8'h01); send(8'h55);
        check("ch2_mod", b_mod, 7'h55);
        send(8'h07); send(8'h11);
        check("ch2_other_cc", b_mod, 7'h55);
        send(8'hE2); send(8'h05); send(8'h12);
        check("ch2_bend_a", b_bend, {7'h12, 7'h05});
        send(8'h00); send(8'h40);
        check("ch2_bend_b", b_bend, 14'h2000);
        send(8'h92); send(8'h3C); send(8'h64); send(8'h40); send(8'h64);
        check("ch2_notes_active", b_active, 4'b0011);
        send(8'hB2); send(8'h7B); send(8'h00);
        check("ch2_all_off", b_active, 4'h0);

        // Reset in the middle of a message
        do_reset();
        send(8'h90); send(8'h3C);
        do_reset();
        send(8'h64);
        check("mid_rst_active", a_active, 4'h0);
        check("mid_rst_trig",   a_trig,   4'h0);
        check("mid_rst_note",   a_note,   28'h0);
        check("mid_rst_vel",    a_vel,    28'h0);
        check("mid_rst_mod",    a_mod,    7'h00);
        check("mid_rst_bend",   a_bend,   14'h2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_voice_allocator.md
MIDI_VOICE_ALLOCATOR -- requirements
Module: midi_voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 4, is the number of polyphonic voice slots (legal range 1..16).
REQ-002 Parameter OMNI, default 1; when 1 all channels are accepted, when 0 only messages on MIDI_CHANNEL are accepted.
REQ-003 Parameter MIDI_CHANNEL, default 0, is the 4-bit accepted channel when OMNI=0.
REQ-004 CLOCK_50  input  1  system clock; all state SHALL change on its rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 byte_valid  input  1  one-cycle strobe qualifying byte_data; at most one byte per cycle.
REQ-007 byte_data  input  8  received MIDI byte.
REQ-008 voice_active  output  NUM_VOICES  bit v high while voice v holds a sounding note.
REQ-009 voice_note  output  7*NUM_VOICES  note number of voice v in bits [7v+6:7v].
REQ-010 voice_velocity  output  7*NUM_VOICES  velocity of voice v in bits [7v+6:7v].
REQ-011 voice_trigger  output  NUM_VOICES  one-cycle pulse on bit v when voice v is newly assigned or retriggered.
REQ-012 mod_value  output  7  last CC1 (modulation) value.
REQ-013 pitch_bend  output  14  last pitch-bend value, {MSB,LSB}.

Function
REQ-014 Byte 0x80-0xEF SHALL latch status nibble and channel as running status and clear the data-byte count.
REQ-015 Byte 0xF0-0xF7 SHALL invalidate running status; following data bytes are discarded until the next channel status byte.
REQ-016 Byte 0xF8-0xFF (real-time) SHALL be ignored without altering running status or data-byte count.
REQ-017 Data byte (bit7=0) with invalid running status SHALL be discarded.
REQ-018 Message length: 2 data bytes for 0x8,0x9,0xA,0xB,0xE; 1 data byte for 0xC,0xD.
REQ-019 On reaching message length the count SHALL return to 0 with running status kept, so further data bytes form new messages.
REQ-020 Completed messages whose channel differs from MIDI_CHANNEL with OMNI=0 SHALL be discarded; 0xA, 0xC, 0xD messages are always discarded.
REQ-021 Outputs SHALL update on the clock edge sampling the completing byte (visible one cycle after its byte_valid cycle).
REQ-022 Note On, velocity>0, note already held in active voice v: voice_velocity[v] updated, voice_trigger[v] pulses, no other voice changes.
REQ-023 Note On, velocity>0, not held: lowest-index inactive voice is assigned (note, velocity, active=1, trigger pulse).
REQ-024 Note On with all voices active: voice at steal pointer is reassigned and triggered; steal pointer increments modulo NUM_VOICES.
REQ-025 Note Off, or Note On with velocity 0: active voice holding that note SHALL clear voice_active; note/velocity retained; no match means no change.
REQ-026 CC1 SHALL set mod_value; CC123 SHALL clear all voice_active bits; other controllers ignored.
REQ-027 Pitch bend SHALL set pitch_bend to {second data byte, first data byte}.
REQ-028 voice_trigger SHALL be zero in all cycles other than those defined in REQ-022..024.

Reset
REQ-029 RESET_N low SHALL immediately clear voice_active, voice_note, voice_velocity, voice_trigger, mod_value, data-byte count, steal pointer, running status (invalid), and set pitch_bend to 14'h2000.
REQ-030 Reset asserted mid-message SHALL discard the partial message; first data byte after release is discarded per REQ-017.

Verification
REQ-031 Bytes 90 3C 64 -> voice 0 active, note 0x3C, velocity 0x64, voice_trigger=0001 for one cycle.
REQ-032 Running status 90 3C 64 40 50 3C 00 -> voice1 note 0x40 active; voice0 released with note 0x3C retained.
REQ-033 NUM_VOICES=4, five Note Ons 0x30..0x34 -> 0x34 steals voice 0, pointer=1; sixth Note On 0x35 steals voice 1.
REQ-034 90 3C F8 64 -> identical to REQ-031; 90 3C F2 64 -> no voice change.
REQ-035 OMNI=0, MIDI_CHANNEL=2: 91 3C 64 ignored; B2 01 55 -> mod_value=0x55; E2 00 40 -> pitch_bend=14'h2000; B2 7B 00 -> all voices inactive.
REQ-036 Assert RESET_N after 90 3C, then release and send 64 -> no voice activated, all outputs at reset values.
